// File: rtl/llc_lookup_sched_pkg.sv
// Shared LLC types plus the lookup scheduler's state encoding and aging limit.
package llc_lookup_sched_pkg;

    localparam int LLC_SET_BITS   = 8;
    localparam int LINE_ADDR_BITS = 26;

    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [LLC_SET_BITS-1:0]   llc_set_t;

    localparam logic       LLC_LOOKUP        = 1'b1;
    localparam logic [3:0] LLC_SCHED_AGE_MAX = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        LOOKUP,
        PRESENT
    } llc_sched_state_t;

    function automatic llc_set_t set_of(input line_addr_t addr);
        return addr[LLC_SET_BITS-1:0];
    endfunction

endpackage

// File: rtl/llc_sched_rr_arb.sv
// Combinational arbiter: aged channels first (round-robin), then channel 0,
// then round-robin over channels 1..NUM_REQ-1 starting at rr_ptr.
module llc_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      rr_ptr,
    input  logic [NUM_REQ-1:0] aged,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      rr_ptr_nxt
);

    logic [NUM_REQ-1:0] elig_hi;
    logic [NUM_REQ-1:0] aged_elig;
    logic [NUM_REQ-1:0] pool;
    logic               found;
    int                 idx;

    assign elig_hi   = eligible & ~NUM_REQ'(1);
    assign aged_elig = elig_hi & aged;

    always_comb begin
        grant      = '0;
        rr_ptr_nxt = rr_ptr;
        found      = 1'b0;
        idx        = 0;
        pool       = '0;
        if (|aged_elig) begin
            pool = aged_elig;
        end else if (eligible[0]) begin
            grant[0] = 1'b1;
        end else begin
            pool = elig_hi;
        end
        // Channel 0 never enters pool; the walk covers only 1..NUM_REQ-1.
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            idx = ((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
            if (!found && pool[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                rr_ptr_nxt = (idx == NUM_REQ - 1) ? PW'(1) : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/llc_lookup_sched.sv
// Shares the LLC tag/state lookup among request channels: grant, RAM read, lookup pulse, present.
// Latency grant->out_valid is 2+RAM_LAT; aging of starved channels enabled by LLC_SCHED_AGING_EN.
module llc_lookup_sched
    import llc_lookup_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RAM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  line_addr_t                 req_addr [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       blocked_set_valid,
    input  llc_set_t                   blocked_set,
    output logic                       rd_set_en,
    output llc_set_t                   rd_set,
    output logic                       lookup_en,
    output logic                       lookup_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output line_addr_t                 out_addr,
    output logic                       sched_busy
);

    localparam int PW  = $clog2(NUM_REQ);
    localparam int WCW = 2;

    llc_sched_state_t   state, state_nxt;
    line_addr_t         lat_addr;
    logic [PW-1:0]      lat_src;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_ptr_nxt;
    logic [WCW-1:0]     wait_cnt;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] aged;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      gnt_idx;
    logic               fire;

    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            eligible[c] = req_valid[c] &&
                          !(blocked_set_valid && (set_of(req_addr[c]) == blocked_set));
        end
    end

`ifdef LLC_SCHED_AGING_EN
    logic [3:0] age [1:NUM_REQ-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 1; c < NUM_REQ; c++) age[c] <= '0;
        end else begin
            for (int c = 1; c < NUM_REQ; c++) begin
                if (!eligible[c]) begin
                    age[c] <= '0;
                end else if (fire) begin
                    if (grant[c])
                        age[c] <= '0;
                    else if (age[c] != LLC_SCHED_AGE_MAX)
                        age[c] <= age[c] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        aged = '0;
        for (int c = 1; c < NUM_REQ; c++) aged[c] = (age[c] == LLC_SCHED_AGE_MAX);
    end
`else
    assign aged = '0;
`endif

    llc_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .aged       (aged),
        .grant      (grant),
        .rr_ptr_nxt (rr_ptr_nxt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (grant[c]) gnt_idx = PW'(c);
        end
    end

    assign fire = (state == IDLE) && (|grant);
    // Grant is masked during reset so every output reads 0 while rst is low.
    assign req_ready = (rst && state == IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_src  <= '0;
            rr_ptr   <= PW'(1);
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                lat_addr <= req_addr[gnt_idx];
                lat_src  <= gnt_idx;
                rr_ptr   <= rr_ptr_nxt;
            end
            if (state == READ)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_set_en  = 1'b0;
        lookup_en  = 1'b0;
        out_valid  = 1'b0;
        sched_busy = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (fire) state_nxt = READ;
            end
            READ: begin
                rd_set_en = 1'b1;
                state_nxt = (RAM_LAT == 1) ? LOOKUP : WAIT;
            end
            WAIT: begin
                // WAIT lasts RAM_LAT-1 cycles so lookup lands RAM_LAT after the read.
                if (int'(wait_cnt) >= RAM_LAT - 2) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                lookup_en = 1'b1;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_set      = rd_set_en ? set_of(lat_addr) : '0;
    assign lookup_mode = lookup_en ? LLC_LOOKUP : 1'b0;
    assign out_src     = lat_src;
    assign out_addr    = lat_addr;

endmodule

// File: tb/tb_llc_lookup_sched.sv
// Directed bench: RAM_LAT=1 instance for most steps, RAM_LAT=3 instance for mid-WAIT reset.
module tb_llc_lookup_sched;
    import llc_lookup_sched_pkg::*;

    localparam int N = 4;

    logic       clk;
    logic       rst, rst3;
    logic [N-1:0] req_valid;
    line_addr_t req_addr [N];
    logic       blocked_set_valid;
    llc_set_t   blocked_set;
    logic       out_ready;

    logic [N-1:0] req_ready1, req_ready3;
    logic       rd_set_en1, rd_set_en3, lookup_en1, lookup_en3;
    logic       lookup_mode1, lookup_mode3, out_valid1, out_valid3;
    logic       sched_busy1, sched_busy3;
    llc_set_t   rd_set1, rd_set3;
    logic [1:0] out_src1, out_src3;
    line_addr_t out_addr1, out_addr3;

    int total = 0;
    int bad   = 0;
    int lk_cnt = 0;
    int lk0;
    int ng;
    int g_ch [8];
    int g_t  [8];
    int exp_ch;

    llc_lookup_sched #(.NUM_REQ(N), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready1), .blocked_set_valid(blocked_set_valid),
        .blocked_set(blocked_set), .rd_set_en(rd_set_en1), .rd_set(rd_set1),
        .lookup_en(lookup_en1), .lookup_mode(lookup_mode1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_src(out_src1), .out_addr(out_addr1),
        .sched_busy(sched_busy1)
    );

    llc_lookup_sched #(.NUM_REQ(N), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready3), .blocked_set_valid(blocked_set_valid),
        .blocked_set(blocked_set), .rd_set_en(rd_set_en3), .rd_set(rd_set3),
        .lookup_en(lookup_en3), .lookup_mode(lookup_mode3), .out_valid(out_valid3),
        .out_ready(out_ready), .out_src(out_src3), .out_addr(out_addr3),
        .sched_busy(sched_busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (lookup_en1) lk_cnt <= lk_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        req_valid = '0; blocked_set_valid = 1'b0; blocked_set = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_addr[i] = '0;
        #1;
        rst = 1'b0; rst3 = 1'b0;
        req_addr[1] = 26'h105;
        req_valid = 4'b0010;
        #1;
        chk("rst_req_ready", 32'(req_ready1), 32'h0);
        chk("rst_rd_set_en", 32'(rd_set_en1), 32'h0);
        chk("rst_lookup_en", 32'(lookup_en1), 32'h0);
        chk("rst_lookup_mode", 32'(lookup_mode1), 32'h0);
        chk("rst_out_valid", 32'(out_valid1), 32'h0);
        chk("rst_busy", 32'(sched_busy1), 32'h0);
        chk("rst_out_addr", 32'(out_addr1), 32'h0);
        chk("rst_out_src", 32'(out_src1), 32'h0);
        chk("rst_rd_set", 32'(rd_set1), 32'h0);
        cyc(); cyc();
        rst = 1'b1;

        // single request on ch1, set 5, then backpressure in PRESENT
        lk0 = lk_cnt;
        #1;
        chk("t1_grant", 32'(req_ready1), 32'h2);
        cyc();
        req_valid = '0;
        chk("t1_rd_set_en", 32'(rd_set_en1), 32'h1);
        chk("t1_rd_set", 32'(rd_set1), 32'h5);
        chk("t1_no_ready_read", 32'(req_ready1), 32'h0);
        chk("t1_no_lookup_read", 32'(lookup_en1), 32'h0);
        cyc();
        chk("t1_lookup_en", 32'(lookup_en1), 32'h1);
        chk("t1_lookup_mode", 32'(lookup_mode1), 32'h1);
        chk("t1_rd_done", 32'(rd_set_en1), 32'h0);
        cyc();
        chk("t1_out_valid", 32'(out_valid1), 32'h1);
        chk("t1_out_src", 32'(out_src1), 32'h1);
        chk("t1_out_addr", 32'(out_addr1), 32'h105);
        req_addr[2] = 26'h208;
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_out_valid", 32'(out_valid1), 32'h1);
            chk("bp_out_src", 32'(out_src1), 32'h1);
            chk("bp_out_addr", 32'(out_addr1), 32'h105);
            chk("bp_no_ready", 32'(req_ready1), 32'h0);
            chk("bp_no_lookup", 32'(lookup_en1), 32'h0);
        end
        req_valid = '0;
        out_ready = 1'b1;
        chk("bp_lookup_once", 32'(lk_cnt - lk0), 32'h1);
        cyc();
        chk("bp_released_valid", 32'(out_valid1), 32'h0);
        chk("bp_released_busy", 32'(sched_busy1), 32'h0);

        // round robin over ch1..3
        rst = 1'b0; cyc(); rst = 1'b1;
        req_addr[1] = 26'h101; req_addr[2] = 26'h102; req_addr[3] = 26'h103;
        req_valid = 4'b1110;
        ng = 0;
        for (int i = 0; i < 17; i++) begin
            #1;
            if (req_ready1 != '0 && ng < 8) begin
                g_ch[ng] = oh_idx(req_ready1);
                g_t[ng]  = i;
                ng++;
            end
            cyc();
        end
        req_valid = '0;
        chk("rr_count", 32'(ng), 32'd5);
        chk("rr_g0", 32'(g_ch[0]), 32'd1);
        chk("rr_g1", 32'(g_ch[1]), 32'd2);
        chk("rr_g2", 32'(g_ch[2]), 32'd3);
        chk("rr_g3", 32'(g_ch[3]), 32'd1);
        chk("rr_g4", 32'(g_ch[4]), 32'd2);
        for (int k = 0; k < 5; k++) chk("rr_time", 32'(g_t[k]), 32'(4 * k));
        cyc(); cyc(); cyc(); cyc();
        chk("rr_idle", 32'(sched_busy1), 32'h0);

        // blocked set: ch1 (set 7) blocked, ch2 (set 8) wins
        rst = 1'b0; cyc(); rst = 1'b1;
        req_addr[1] = 26'h307; req_addr[2] = 26'h308;
        blocked_set_valid = 1'b1; blocked_set = 8'h07;
        req_valid = 4'b0110;
        #1;
        chk("blk_grant_ch2", 32'(req_ready1), 32'h4);
        cyc();
        req_valid = 4'b0010;
        blocked_set = 8'h08;
        #1;
        chk("blk_rd_set", 32'(rd_set1), 32'h8);
        cyc(); cyc();
        chk("blk_out_valid", 32'(out_valid1), 32'h1);
        chk("blk_out_src", 32'(out_src1), 32'h2);
        chk("blk_out_addr", 32'(out_addr1), 32'h308);
        cyc();
        chk("blk_grant_ch1", 32'(req_ready1), 32'h2);
        req_valid = '0;
        blocked_set_valid = 1'b0;

        // reset during WAIT on the RAM_LAT=3 instance
        rst = 1'b0; rst3 = 1'b1;
        out_ready = 1'b0;
        req_addr[1] = 26'h105;
        req_valid = 4'b0010;
        #1;
        chk("r3_grant", 32'(req_ready3), 32'h2);
        cyc();
        chk("r3_rd_set_en", 32'(rd_set_en3), 32'h1);
        cyc();
        chk("r3_wait_busy", 32'(sched_busy3), 32'h1);
        chk("r3_wait_no_lookup", 32'(lookup_en3), 32'h0);
        rst3 = 1'b0;
        #1;
        chk("r3_rst_ready", 32'(req_ready3), 32'h0);
        chk("r3_rst_busy", 32'(sched_busy3), 32'h0);
        chk("r3_rst_rd", 32'(rd_set_en3), 32'h0);
        chk("r3_rst_lookup", 32'(lookup_en3), 32'h0);
        chk("r3_rst_out_valid", 32'(out_valid3), 32'h0);
        chk("r3_rst_out_addr", 32'(out_addr3), 32'h0);
        cyc();
        rst3 = 1'b1;
        #1;
        chk("r3_regrant", 32'(req_ready3), 32'h2);
        cyc();
        req_valid = '0;
        chk("r3_rd_after", 32'(rd_set_en3), 32'h1);
        chk("r3_rd_set", 32'(rd_set3), 32'h5);
        cyc();
        chk("r3_w1_lookup", 32'(lookup_en3), 32'h0);
        cyc();
        chk("r3_w2_lookup", 32'(lookup_en3), 32'h0);
        cyc();
        chk("r3_lookup", 32'(lookup_en3), 32'h1);
        cyc();
        chk("r3_out_valid", 32'(out_valid3), 32'h1);
        chk("r3_out_src", 32'(out_src3), 32'h1);
        out_ready = 1'b1;
        cyc();
        rst3 = 1'b0;

        // aging: ch0 and ch1 always valid
        rst = 1'b1;
        req_addr[0] = 26'h010; req_addr[1] = 26'h011;
        req_valid = 4'b0011;
        for (int g = 0; g < 20; g++) begin
            for (int w = 0; w < 10 && req_ready1 == '0; w++) cyc();
`ifdef LLC_SCHED_AGING_EN
            exp_ch = (g == 15) ? 1 : 0;
`else
            exp_ch = 0;
`endif
            if (req_ready1 == '0) begin
                chk("age_timeout", 32'(req_ready1), 32'(1 << exp_ch));
            end else begin
                chk("age_grant", 32'(oh_idx(req_ready1)), 32'(exp_ch));
            end
            cyc();
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
